// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs, state codes,
// datapath select encodings and the one-hot instruction class.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_JR   = 6'h08;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;

  typedef struct packed {
    logic alu_r;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic illegal;
  } inst_cls_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational op/funct classifier: exactly one class bit is set for any input.
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output inst_cls_t  cls
);

  always_comb begin
    cls = '0;
    case (op)
      OP_R: begin
        case (funct)
          FN_ADDU, FN_SUBU: cls.alu_r   = 1'b1;
          FN_JR:            cls.jr      = 1'b1;
          default:          cls.illegal = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori     = 1'b1;
      OP_LUI:  cls.lui     = 1'b1;
      OP_LW:   cls.lw      = 1'b1;
      OP_SW:   cls.sw      = 1'b1;
      OP_BEQ:  cls.beq     = 1'b1;
      OP_J:    cls.j       = 1'b1;
      OP_JAL:  cls.jal     = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main controller. Optional retire counter enabled by MC_CTRL_RETIRE_CNT_EN.
//   state  | meaning
//   FETCH  | request instruction, wait imem_ready, load IR and PC+4
//   DECODE | resolve jumps / illegal, otherwise go execute
//   EXEC   | drive ALU operands and op; beq resolves here
//   MEM    | data access, wait dmem_ready
//   WB     | register file write, retire
module mc_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 3
`ifdef MC_CTRL_RETIRE_CNT_EN
  , parameter int RCNT_W = 32
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic [1:0]         NPCSel,
  output logic               ALUSrc,
  output logic [2:0]         ALUOp,
  output logic [1:0]         ExtOp,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               retire,
  output logic               illegal,
`ifdef MC_CTRL_RETIRE_CNT_EN
  output logic [RCNT_W-1:0]  retire_cnt,
`endif
  output logic [STATE_W-1:0] state
);

  state_e    state_q, state_d;
  inst_cls_t cls;
  logic      is_sub;

  mc_ctrl_decode u_decode (
    .op    (op),
    .funct (funct),
    .cls   (cls)
  );

  assign is_sub = (funct == FN_SUBU);
  assign state  = STATE_W'(state_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (imem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (cls.j || cls.jal || cls.jr || cls.illegal) state_d = ST_FETCH;
        else                                           state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (cls.alu_r || cls.ori || cls.lui) state_d = ST_WB;
        else if (cls.lw || cls.sw)           state_d = ST_MEM;
        else                                 state_d = ST_FETCH;
      end
      ST_MEM: if (dmem_ready) state_d = cls.lw ? ST_WB : ST_FETCH;
      ST_WB:   state_d = ST_FETCH;
      default: state_d = ST_FETCH;
    endcase
  end

  // Outputs are forced low while reset is held, so no strobe leaks during reset.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    NPCSel   = NPC_PC4;
    ALUSrc   = 1'b0;
    ALUOp    = ALU_ADD;
    ExtOp    = EXT_ZERO;
    RegDst   = RDST_RT;
    MemtoReg = M2R_ALU;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    retire   = 1'b0;
    illegal  = 1'b0;
    if (reset) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
          end
        end
        ST_DECODE: begin
          if (cls.j || cls.jal) begin
            PCWrite = 1'b1;
            NPCSel  = NPC_J;
            retire  = 1'b1;
            if (cls.jal) begin
              RegWrite = 1'b1;
              RegDst   = RDST_RA;
              MemtoReg = M2R_PC;
            end
          end else if (cls.jr) begin
            PCWrite = 1'b1;
            NPCSel  = NPC_JR;
            retire  = 1'b1;
          end else if (cls.illegal) begin
            illegal = 1'b1;
          end
        end
        ST_EXEC: begin
          if (cls.alu_r) begin
            ALUOp = is_sub ? ALU_SUB : ALU_ADD;
          end else if (cls.ori) begin
            ALUSrc = 1'b1;
            ALUOp  = ALU_OR;
          end else if (cls.lui) begin
            ALUSrc = 1'b1;
            ALUOp  = ALU_LUI;
          end else if (cls.lw || cls.sw) begin
            ALUSrc = 1'b1;
            ExtOp  = EXT_SIGN;
          end else if (cls.beq) begin
            ALUOp   = ALU_SUB;
            ExtOp   = EXT_SIGN;
            PCWrite = zero;
            NPCSel  = NPC_BR;
            retire  = 1'b1;
          end
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          ALUSrc   = 1'b1;
          ExtOp    = EXT_SIGN;
          if (cls.sw) begin
            MemWrite = dmem_ready;
            retire   = dmem_ready;
          end
        end
        ST_WB: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
          if (cls.alu_r) RegDst   = RDST_RD;
          if (cls.lw)    MemtoReg = M2R_MEM;
        end
        default: ;
      endcase
    end
  end

`ifdef MC_CTRL_RETIRE_CNT_EN
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;

  assign rcnt_d     = retire ? rcnt_q + 1'b1 : rcnt_q;
  assign retire_cnt = rcnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rcnt_q <= '0;
    else        rcnt_q <= rcnt_d;
  end
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: per-cycle expected states and per-instruction
// expected summaries are queued by the stimulus and checked by an independent monitor.
module tb_mc_ctrl_fsm;

  localparam int S_F = 0, S_D = 1, S_E = 2, S_M = 3, S_W = 4;
  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_SW = 5,
                 K_BEQ = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_ILL = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, imem_ready, dmem_ready;
  logic       imem_req, dmem_req, IRWrite, PCWrite, ALUSrc, RegWrite, MemWrite;
  logic       retire, illegal;
  logic [1:0] NPCSel, ExtOp, RegDst, MemtoReg;
  logic [2:0] ALUOp;
  logic [2:0] state;
`ifdef MC_CTRL_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  mc_ctrl_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .NPCSel     (NPCSel),
    .ALUSrc     (ALUSrc),
    .ALUOp      (ALUOp),
    .ExtOp      (ExtOp),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .retire     (retire),
    .illegal    (illegal),
`ifdef MC_CTRL_RETIRE_CNT_EN
    .retire_cnt (retire_cnt),
`endif
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ill, lat, rw, mw, pcw, npc, rdst, m2r, ireq, dreq, esig;
  } exp_t;

  exp_t exp_q[$];
  int   st_q[$];
  int   n_cmp = 0, n_bad = 0;
  bit   mon_en = 1'b0;
  int   m_rcnt = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic int sig(input int src, input int aop, input int ext);
    return (src << 5) | (aop << 2) | ext;
  endfunction

  function automatic int all_outs();
    return int'({imem_req, dmem_req, IRWrite, PCWrite, NPCSel, ALUSrc, ALUOp, ExtOp,
                 RegDst, MemtoReg, RegWrite, MemWrite, retire, illegal});
  endfunction

  // Monitor: per-cycle state check, per-instruction summary on retire/illegal.
  int a_cyc = 0, a_rw = 0, a_mw = 0, a_pcw = 0, a_npc = 0, a_rdst = 0, a_m2r = 0;
  int a_ireq = 0, a_dreq = 0, a_irw = 0, a_esig = 0, a_membad = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      a_cyc++;
      if (RegWrite) begin a_rw++; a_rdst = int'(RegDst); a_m2r = int'(MemtoReg); end
      if (MemWrite) a_mw++;
      if (PCWrite) begin a_pcw++; a_npc = int'(NPCSel); end
      if (imem_req) a_ireq++;
      if (dmem_req) a_dreq++;
      if (IRWrite) a_irw++;
      if (state == 3'(S_E)) a_esig = sig(int'(ALUSrc), int'(ALUOp), int'(ExtOp));
      if (state == 3'(S_M) && sig(int'(ALUSrc), int'(ALUOp), int'(ExtOp)) != sig(1, 0, 1))
        a_membad = 1;
      chk("rw_and_mw", int'(RegWrite & MemWrite), 0);
      if (st_q.size() == 0) chk("state_q_underflow", 1, 0);
      else chk("state", int'(state), st_q.pop_front());
      if (retire || illegal) begin
        if (exp_q.size() == 0) chk("unexpected_completion", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("illegal_pulse", int'(illegal), e.ill);
          chk("retire_pulse", int'(retire), 1 - e.ill);
          chk("latency", a_cyc, e.lat);
          chk("regwrite_cycles", a_rw, e.rw);
          chk("memwrite_cycles", a_mw, e.mw);
          chk("pcwrite_cycles", a_pcw, e.pcw);
          chk("npcsel_last", a_npc, e.npc);
          chk("regdst", a_rdst, e.rdst);
          chk("memtoreg", a_m2r, e.m2r);
          chk("imem_req_cycles", a_ireq, e.ireq);
          chk("dmem_req_cycles", a_dreq, e.dreq);
          chk("irwrite_cycles", a_irw, 1);
          chk("exec_signals", a_esig, e.esig);
          chk("mem_signals_stable", a_membad, 0);
`ifdef MC_CTRL_RETIRE_CNT_EN
          chk("retire_cnt", int'(retire_cnt), m_rcnt);
`endif
          if (e.ill == 0) m_rcnt++;
        end
        a_cyc = 0; a_rw = 0; a_mw = 0; a_pcw = 0; a_npc = 0; a_rdst = 0; a_m2r = 0;
        a_ireq = 0; a_dreq = 0; a_irw = 0; a_esig = 0; a_membad = 0;
      end
    end
  end

  // Reference model: instruction-level expectations from the controller's rules.
  function automatic exp_t model(input int k, input int wi, input int wd, input bit bz);
    exp_t e;
    e = '{default: 0};
    e.ill  = (k == K_ILL);
    e.ireq = wi + 1;
    case (k)
      K_J, K_JAL, K_JR, K_ILL: e.lat = 2;
      K_BEQ:                   e.lat = 3;
      K_LW:                    e.lat = 5 + wd;
      K_SW:                    e.lat = 4 + wd;
      default:                 e.lat = 4;
    endcase
    e.lat += wi;
    e.rw   = (k inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_JAL}) ? 1 : 0;
    e.mw   = (k == K_SW) ? 1 : 0;
    e.dreq = (k == K_LW || k == K_SW) ? wd + 1 : 0;
    e.pcw  = 1 + ((k inside {K_J, K_JAL, K_JR}) ? 1 : 0) + ((k == K_BEQ && bz) ? 1 : 0);
    case (k)
      K_J, K_JAL: e.npc = 2;
      K_JR:       e.npc = 3;
      K_BEQ:      e.npc = bz ? 1 : 0;
      default:    e.npc = 0;
    endcase
    e.rdst = (k == K_ADDU || k == K_SUBU) ? 1 : (k == K_JAL) ? 2 : 0;
    e.m2r  = (k == K_LW) ? 1 : (k == K_JAL) ? 2 : 0;
    case (k)
      K_SUBU:     e.esig = sig(0, 1, 0);
      K_ORI:      e.esig = sig(1, 2, 0);
      K_LUI:      e.esig = sig(1, 3, 0);
      K_LW, K_SW: e.esig = sig(1, 0, 1);
      K_BEQ:      e.esig = sig(0, 1, 1);
      default:    e.esig = 0;
    endcase
    return e;
  endfunction

  task automatic run_inst(input int k, input logic [5:0] o, input logic [5:0] f,
                          input int wi, input int wd, input bit bz);
    int st[$];
    int last_mem;
    for (int i = 0; i <= wi; i++) st.push_back(S_F);
    st.push_back(S_D);
    if (k inside {K_ADDU, K_SUBU, K_ORI, K_LUI}) begin
      st.push_back(S_E); st.push_back(S_W);
    end else if (k == K_BEQ) begin
      st.push_back(S_E);
    end else if (k == K_LW || k == K_SW) begin
      st.push_back(S_E);
      for (int i = 0; i <= wd; i++) st.push_back(S_M);
      if (k == K_LW) st.push_back(S_W);
    end
    last_mem = -1;
    foreach (st[i]) if (st[i] == S_M) last_mem = i;
    exp_q.push_back(model(k, wi, wd, bz));
    foreach (st[c]) begin
      @(posedge clk); #1;
      mon_en     = 1'b1;
      op         = o;
      funct      = f;
      imem_ready = (st[c] == S_F) ? (c == wi) : 1'($urandom);
      dmem_ready = (st[c] == S_M) ? (c == last_mem) : 1'($urandom);
      zero       = (st[c] == S_E && k == K_BEQ) ? bz : 1'($urandom);
      st_q.push_back(st[c]);
    end
  endtask

  task automatic pick(input int k, output logic [5:0] o, output logic [5:0] f);
    f = 6'($urandom);
    case (k)
      K_ADDU: begin o = 6'h00; f = 6'h21; end
      K_SUBU: begin o = 6'h00; f = 6'h23; end
      K_JR:   begin o = 6'h00; f = 6'h08; end
      K_ORI:  o = 6'h0D;
      K_LUI:  o = 6'h0F;
      K_LW:   o = 6'h23;
      K_SW:   o = 6'h2B;
      K_BEQ:  o = 6'h04;
      K_J:    o = 6'h02;
      K_JAL:  o = 6'h03;
      default: begin
        if ($urandom_range(0, 1) == 0) begin
          o = 6'h00;
          while (f inside {6'h21, 6'h23, 6'h08}) f = 6'($urandom);
        end else begin
          o = 6'($urandom);
          while (o inside {6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03})
            o = 6'($urandom);
        end
      end
    endcase
  endtask

  initial begin
    logic [5:0] o, f;
    bit seen;
    int k;
    reset = 1'b0; op = 6'h00; funct = 6'h21; zero = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", all_outs(), 0);
    chk("reset_state", int'(state), S_F);
    @(posedge clk); #1 reset = 1'b1;

    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (state == 3'(S_W)) seen = 1'b1;
    end
    chk("reach_wb_addu", int'(seen), 1);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("midwb_reset_outputs", all_outs(), 0);
      chk("midwb_reset_state", int'(state), S_F);
`ifdef MC_CTRL_RETIRE_CNT_EN
      chk("reset_retire_cnt", int'(retire_cnt), 0);
`endif
      @(negedge clk);
    end
    @(posedge clk); #1;
    imem_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_imem_req", int'(imem_req), 1);
    chk("post_reset_regwrite", int'(RegWrite), 0);

    run_inst(K_ADDU, 6'h00, 6'h21, 0, 0, 1'b0);
    run_inst(K_LW, 6'h23, 6'h11, 0, 2, 1'b0);
    run_inst(K_ILL, 6'h3F, 6'h00, 0, 0, 1'b0);
    run_inst(K_JAL, 6'h03, 6'h05, 0, 0, 1'b0);
    run_inst(K_SW, 6'h2B, 6'h00, 0, 0, 1'b0);
    run_inst(K_BEQ, 6'h04, 6'h00, 0, 0, 1'b1);
    run_inst(K_BEQ, 6'h04, 6'h00, 0, 0, 1'b0);
    run_inst(K_JR, 6'h00, 6'h08, 1, 0, 1'b0);
    run_inst(K_SUBU, 6'h00, 6'h23, 2, 0, 1'b0);
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 10);
      pick(k, o, f);
      run_inst(k, o, f, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
               $urandom_range(0, 3), 1'($urandom));
    end
    @(negedge clk); #1;
    mon_en = 1'b0;
    imem_ready = 1'b0;
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("state_queue_drained", st_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle main controller for the MIPS datapath.
- Sequences one instruction through FETCH/DECODE/EXEC/MEM/WB, reusing the single ALU and the ALU-B operand select across states.
- Drives every datapath control strobe: ALUSrc (1 = extended immediate, 0 = RData2), register/memory write enables, PC update select.
- Handshakes with instruction and data memories via ready signals.
- Supported instructions: addu, subu, ori, lui, lw, sw, beq, j, jal, jr.

Parameters:
- STATE_W, 3, width of state register/debug output.
- RCNT_W, 32, width of retire counter (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data access completes this cycle.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- IRWrite  out  1  load IR.
- PCWrite  out  1  update PC.
- NPCSel  out  2  00 PC+4, 01 branch target, 10 j/jal target, 11 rs (jr).
- ALUSrc  out  1  1 selects Extended, 0 selects RData2.
- ALUOp  out  3  000 add, 001 sub, 010 or, 011 lui (imm<<16).
- ExtOp  out  2  00 zero-ext, 01 sign-ext.
- RegDst  out  2  00 rt, 01 rd, 10 $31.
- MemtoReg  out  2  00 ALU result, 01 memory data, 10 PC (already PC+4).
- RegWrite  out  1  GRF write enable.
- MemWrite  out  1  DM write enable.
- retire  out  1  one-cycle pulse on instruction completion.
- illegal  out  1  one-cycle pulse on unsupported op/funct.
- state  out  STATE_W  current state (debug).

Behaviour:
- Encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5–7 unreachable and force next state FETCH.
- Reset (reset=0, asynchronous):
  - state=FETCH.
  - All outputs 0 while reset is asserted, including imem_req.
  - Reset mid-instruction abandons it: no write strobe fires.
- Register/output structure: state register only. Outputs are combinational from state, op/funct, zero and the ready inputs. Default for every output is 0 unless listed below.
- FETCH:
  - imem_req=1.
  - Hold while imem_ready=0.
  - On imem_ready=1: IRWrite=1, PCWrite=1, NPCSel=00 → DECODE.
- DECODE (always exactly 1 cycle, op/funct valid):
  - j: PCWrite=1, NPCSel=10, retire=1 → FETCH.
  - jal: same as j, plus RegWrite=1, RegDst=10, MemtoReg=10.
  - jr (op=0, funct=0x08): PCWrite=1, NPCSel=11, retire=1 → FETCH.
  - Unsupported op or R-funct: illegal=1, no writes, no retire → FETCH.
  - All others → EXEC.
- EXEC:
  - addu: ALUSrc=0, ALUOp=000 → WB.
  - subu: ALUSrc=0, ALUOp=001 → WB.
  - ori: ALUSrc=1, ExtOp=00, ALUOp=010 → WB.
  - lui: ALUSrc=1, ALUOp=011 → WB.
  - lw/sw: ALUSrc=1, ExtOp=01, ALUOp=000 → MEM.
  - beq: ALUSrc=0, ALUOp=001, ExtOp=01; PCWrite=zero, NPCSel=01, retire=1 → FETCH.
- MEM:
  - dmem_req=1; keep ALUSrc=1, ExtOp=01, ALUOp=000 stable.
  - sw: MemWrite=dmem_ready. On ready: retire=1 → FETCH.
  - lw: on ready → WB.
  - Hold while dmem_ready=0.
- WB:
  - RegWrite=1, retire=1 → FETCH.
  - R-type: RegDst=01, MemtoReg=00.
  - ori/lui: RegDst=00, MemtoReg=00.
  - lw: RegDst=00, MemtoReg=01.
- Latency in cycles, with zero memory wait:
  - j/jal/jr: 2.
  - beq: 3.
  - ALU ops: 4.
  - sw: 4.
  - lw: 5.
  - Each memory wait cycle adds 1.
- Ready inputs are ignored outside their own states; imem_ready in MEM has no effect.
- Never assert RegWrite and MemWrite in the same cycle.

Optional Feature:
- Macro: MC_CTRL_RETIRE_CNT_EN.
- Defined:
  - Adds output retire_cnt[RCNT_W-1:0].
  - Increments by 1 on every retire pulse; wraps from all-ones to 0.
  - Cleared to 0 by reset; illegal instructions do not count.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode/funct constants (R=0x00, ori=0x0D, lui=0x0F, lw=0x23, sw=0x2B, beq=0x04, j=0x02, jal=0x03; funct addu=0x21, subu=0x23, jr=0x08);
  - state codes;
  - ALUOp, NPCSel, RegDst, MemtoReg, ExtOp encodings.
- One sub-module: mc_ctrl_decode, purely combinational. Maps op/funct to a one-hot instruction class (alu_r, ori, lui, lw, sw, beq, j, jal, jr, illegal), which the FSM consumes.

Test Plan:
- reset=0 held 3 cycles mid-WB of addu → all outputs 0, state=0; after release, first cycle shows imem_req=1, RegWrite=0.
- addu (op 0x00, funct 0x21), imem_ready=1 every cycle → states 0,1,2,4; RegWrite=1 with RegDst=01 only in cycle 4; retire once.
- lw (0x23), dmem_ready low 2 cycles → MEM lasts 3 cycles with dmem_req=1, MemWrite=0; then WB with MemtoReg=01; total 7 cycles.
- sw (0x2B), dmem_ready=1 → MemWrite=1 exactly one cycle in MEM, ALUSrc=1, no RegWrite; 4 cycles.
- beq with zero=1, then zero=0 → PCWrite=1/NPCSel=01 in EXEC for the first; PCWrite=0 for the second; both retire.
- op 0x3F → illegal pulse in DECODE, no writes, back to FETCH. jal → RegWrite=1, RegDst=10, MemtoReg=10 in DECODE. With MC_CTRL_RETIRE_CNT_EN, the sequence addu, lw, illegal, jal leaves retire_cnt=3.
